avalon_mm_ctrl_slave: RTL
=========================

AVALON_MM_CTRL_SLAVE -- requirements
Module: avalon_mm_ctrl_slave

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning the fixed cycles from read acceptance to readdatavalid (legal 1..4).
REQ-002 SHALL have parameter START_CODE, default 32'hF00BF00B, meaning the control-word value that starts a run.
REQ-003 SHALL have parameter STOP_CODE, default 32'hDEADF00B, meaning the control-word value that stops a run.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 avs_address  input  5  byte address; word index = avs_address[4:2]; avs_address[1:0] ignored.
REQ-007 avs_read  input  1  read request.
REQ-008 avs_write  input  1  write request.
REQ-009 avs_writedata  input  32  write data.
REQ-010 avs_byteenable  input  4  per-byte write enable.
REQ-011 avs_waitrequest  output  1  stall; request not accepted while high.
REQ-012 avs_readdata  output  32  read data; valid only with avs_readdatavalid.
REQ-013 avs_readdatavalid  output  1  read data valid strobe.
REQ-014 run  output  1  run state level.
REQ-015 start_pulse  output  1  one-cycle strobe on an accepted start.
REQ-016 stop_pulse  output  1  one-cycle strobe on an accepted stop of an active run.

Function
REQ-017 Register map SHALL be:
  - word 0, CTRL/STATUS: R/W
  - word 1, CYCLE_CNT: RO; writes ignored
  - words 2..7, GP0..GP5: R/W (byte addresses 8..28)
REQ-018 A request SHALL be accepted in a cycle where (avs_read XOR avs_write) is high and avs_waitrequest is low.
REQ-019 avs_read and avs_write high together SHALL be accepted as neither, SHALL set sticky proto_err, and SHALL not assert waitrequest.
REQ-020 GP writes SHALL update only the bytes with avs_byteenable set; effect SHALL be visible to a read accepted the next cycle.
REQ-021 CTRL writes SHALL act only when avs_byteenable == 4'hF; otherwise ignored with no stall.
REQ-022 CTRL write of START_CODE:
  - run <= 1, CYCLE_CNT <= 0, start_pulse high the next cycle
  - start_cnt += 1 (8-bit, wraps 255->0)
  - also applies when already running (restart)
REQ-023 CTRL write of STOP_CODE:
  - run <= 0, stop_pulse high the next cycle, only if run was 1
  - if not running: no state change, no pulse
REQ-024 CTRL write of 32'h00000002 SHALL clear proto_err; all other CTRL values SHALL be ignored.
REQ-025 Every accepted full-byteenable CTRL write SHALL assert avs_waitrequest for exactly the following cycle; no other case stalls after reset.
REQ-026 CYCLE_CNT SHALL increment by 1 each cycle while run=1 and hold while run=0; it SHALL wrap 32'hFFFFFFFF->0; the start-cycle clear overrides the increment.
REQ-027 CTRL read data SHALL be {16'h0, start_cnt[7:0], 6'h0, proto_err, run}.
REQ-028 Read data SHALL be sampled in the acceptance cycle N and presented with avs_readdatavalid=1 in cycle N+READ_LATENCY.
REQ-029 Back-to-back reads (one per cycle) SHALL be fully pipelined and returned in order; there SHALL be no read backpressure.
REQ-030 avs_readdata SHALL be 0 when avs_readdatavalid is 0.

Reset
REQ-031 While reset is high SHALL hold:
  - avs_waitrequest=1
  - all other outputs 0
  - all registers and counters 0
  - read pipeline flushed
REQ-032 In the first cycle after reset deasserts, avs_waitrequest SHALL be 0.
REQ-033 Reads in flight when reset asserts SHALL never produce readdatavalid.

Verification
REQ-034 Write GP0..GP5 (addr 8..28) = 1111F000..6666F000, byteenable F; read each -> matching data exactly 2 cycles after acceptance; 6 back-to-back reads give 6 consecutive valid cycles in order.
REQ-035 Write addr 0 = F00BF00B -> start_pulse 1 cycle, run=1, waitrequest high 1 cycle; after 40 cycles read addr 4 -> value 40 +/-1 per the sampling point, checked exactly against the model.
REQ-036 Write addr 0 = DEADF00B while running -> stop_pulse, run=0, CYCLE_CNT frozen; second STOP -> no pulse; read addr 0 -> 32'h00000100.
REQ-037 Assert read and write together -> no access, no stall; read addr 0 bit1=1; write 0x2 -> bit1=0; GP write with byteenable 4'b0101 over 0xFFFFFFFF with data 0 -> 0xFF00FF00.
REQ-038 Force CYCLE_CNT near wrap (run 2^32 cycles or backdoor 0xFFFFFFFE) -> counts FFFFFFFF, 00000000, 00000001.
REQ-039 Assert reset with 2 reads in flight -> no readdatavalid, all registers 0, waitrequest high during reset and 0 on the first cycle after.

Source files
------------

// File: rtl/avalon_mm_ctrl_slave_if.sv
// avalon_mm_ctrl_slave_if: Avalon-MM slave bus bundle for the control block
interface avalon_mm_ctrl_slave_if;
   logic [4:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_waitrequest;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_waitrequest, avs_readdata, avs_readdatavalid
   );
   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_waitrequest, avs_readdata, avs_readdatavalid
   );
endinterface

// File: rtl/avalon_mm_ctrl_slave.sv
// avalon_mm_ctrl_slave: run/stop control register block with cycle counter and GP registers
module avalon_mm_ctrl_slave #(
   parameter int          READ_LATENCY = 2,
   parameter logic [31:0] START_CODE   = 32'hF00BF00B,
   parameter logic [31:0] STOP_CODE    = 32'hDEADF00B
) (
   input  logic                   clk,
   input  logic                   reset,
   avalon_mm_ctrl_slave_if.slave  bus,
   output logic                   run,
   output logic                   start_pulse,
   output logic                   stop_pulse
);
   logic [2:0]  word, gp_idx;
   logic        accept_rd, accept_wr, ctrl_wr, do_start, do_stop, do_clear;
   logic        stall_q, run_q, start_q, stop_q, proto_err;
   logic [7:0]  start_cnt;
   logic [31:0] cycle_cnt, rd_mux;
   logic [31:0] gp [6];
   logic [READ_LATENCY-1:0] pipe_v;
   logic [31:0] pipe_d [READ_LATENCY];
   logic        unused_addr;
   assign unused_addr = ^bus.avs_address[1:0];
   always_comb begin
      word      = bus.avs_address[4:2];
      gp_idx    = word - 3'd2;
      accept_rd = bus.avs_read & ~bus.avs_write & ~bus.avs_waitrequest;
      accept_wr = bus.avs_write & ~bus.avs_read & ~bus.avs_waitrequest;
      ctrl_wr   = accept_wr && word == 3'd0 && bus.avs_byteenable == 4'hF;
      do_start  = ctrl_wr && bus.avs_writedata == START_CODE;
      do_stop   = ctrl_wr && bus.avs_writedata == STOP_CODE && run_q;
      do_clear  = ctrl_wr && bus.avs_writedata == 32'h2;
      rd_mux    = word == 3'd0 ? {16'h0, start_cnt, 6'h0, proto_err, run_q} :
                  word == 3'd1 ? cycle_cnt : gp[gp_idx];
   end
   // Outputs are gated by reset so nothing leaks out before the first reset edge clears state.
   always_comb begin
      bus.avs_waitrequest   = reset | stall_q;
      bus.avs_readdatavalid = pipe_v[READ_LATENCY-1] & ~reset;
      bus.avs_readdata      = bus.avs_readdatavalid ? pipe_d[READ_LATENCY-1] : 32'h0;
      run                   = run_q & ~reset;
      start_pulse           = start_q & ~reset;
      stop_pulse            = stop_q & ~reset;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q   <= 1'b0;
         run_q     <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         proto_err <= 1'b0;
         start_cnt <= 8'h0;
         cycle_cnt <= 32'h0;
         pipe_v    <= '0;
         for (int i = 0; i < 6; i++) gp[i] <= 32'h0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] <= 32'h0;
      end else begin
         stall_q   <= ctrl_wr;
         start_q   <= do_start;
         stop_q    <= do_stop;
         run_q     <= do_start | (run_q & ~do_stop);
         proto_err <= (bus.avs_read & bus.avs_write) | (proto_err & ~do_clear);
         start_cnt <= start_cnt + 8'(do_start);
         cycle_cnt <= do_start ? 32'h0 : run_q ? cycle_cnt + 32'd1 : cycle_cnt;
         for (int i = 0; i < 4; i++)
            if (accept_wr && word >= 3'd2 && bus.avs_byteenable[i])
               gp[gp_idx][8*i +: 8] <= bus.avs_writedata[8*i +: 8];
         pipe_v[0] <= accept_rd;
         pipe_d[0] <= rd_mux;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end
endmodule
